// File: rtl/id_stage.sv
// RV32I decode stage with ID/EX pipeline register.
// Decodes one instruction per cycle behind a valid/ready handshake with flush.
package id_pkg;

  localparam logic [4:0] ALU_X    = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SLL  = 5'd3;
  localparam logic [4:0] ALU_SLT  = 5'd4;
  localparam logic [4:0] ALU_SLTU = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_OR   = 5'd9;
  localparam logic [4:0] ALU_AND  = 5'd10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  alu_fn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        rf_wen;
    logic [1:0]  wb_sel;
    logic        mem_wen;
    logic        mem_ren;
    logic [2:0]  mem_fn;
    logic        br_en;
    logic [2:0]  br_fn;
    logic        jump;
    logic        illegal;
  } id_bundle_t;

endpackage

module id_stage
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_alu_fn,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rd_addr,
  output logic            out_rf_wen,
  output logic [1:0]      out_wb_sel,
  output logic            out_mem_wen,
  output logic            out_mem_ren,
  output logic [2:0]      out_mem_fn,
  output logic            out_br_en,
  output logic [2:0]      out_br_fn,
  output logic            out_jump,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  function automatic logic [4:0] base_fn(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_X;
    endcase
  endfunction

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [4:0]  rd_s;
  logic [31:0] rs1_val_s, rs2_val_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic        illegal_s;
  logic        load_s;
  id_bundle_t  dec_s;
  id_bundle_t  bundle_d, bundle_q;
  logic        valid_d, valid_q;

  assign opcode_s    = in_inst[6:0];
  assign funct3_s    = in_inst[14:12];
  assign funct7_s    = in_inst[31:25];
  assign rd_s        = in_inst[11:7];
  assign rf_rs1_addr = in_inst[19:15];
  assign rf_rs2_addr = in_inst[24:20];

  // x0 always reads as zero, whatever the regfile returns
  assign rs1_val_s = (rf_rs1_addr == 5'd0) ? 32'd0 : rf_rs1_data;
  assign rs2_val_s = (rf_rs2_addr == 5'd0) ? 32'd0 : rf_rs2_data;

  assign imm_i_s = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b_s = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u_s = {in_inst[31:12], 12'd0};
  assign imm_j_s = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Instruction decode and operand selection
  always_comb begin
    dec_s          = '0;
    dec_s.pc       = in_pc;
    dec_s.rs1_data = rs1_val_s;
    dec_s.rs2_data = rs2_val_s;
    dec_s.alu_fn   = ALU_X;
    illegal_s      = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        dec_s.op1     = rs1_val_s;
        dec_s.op2     = (funct3_s[1:0] == 2'b01) ? {27'd0, rs2_val_s[4:0]} : rs2_val_s;
        dec_s.rd_addr = rd_s;
        dec_s.rf_wen  = (rd_s != 5'd0);
        if (funct7_s == F7_BASE) begin
          dec_s.alu_fn = base_fn(funct3_s);
        end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b000)) begin
          dec_s.alu_fn = ALU_SUB;
        end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b101)) begin
          dec_s.alu_fn = ALU_SRA;
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_s.op1     = rs1_val_s;
        dec_s.op2     = imm_i_s;
        dec_s.rd_addr = rd_s;
        dec_s.rf_wen  = (rd_s != 5'd0);
        dec_s.alu_fn  = base_fn(funct3_s);
        // shift immediates carry the SRA selector in imm[11:5]
        if (funct3_s == 3'b001) begin
          dec_s.op2 = {27'd0, in_inst[24:20]};
          illegal_s = (funct7_s != F7_BASE);
        end else if (funct3_s == 3'b101) begin
          dec_s.op2 = {27'd0, in_inst[24:20]};
          if (funct7_s == F7_ALT) begin
            dec_s.alu_fn = ALU_SRA;
          end else begin
            illegal_s = (funct7_s != F7_BASE);
          end
        end else begin
          illegal_s = 1'b0;
        end
      end
      OPC_LOAD: begin
        dec_s.alu_fn  = ALU_ADD;
        dec_s.op1     = rs1_val_s;
        dec_s.op2     = imm_i_s;
        dec_s.rd_addr = rd_s;
        dec_s.rf_wen  = (rd_s != 5'd0);
        dec_s.wb_sel  = WB_MEM;
        dec_s.mem_ren = 1'b1;
        dec_s.mem_fn  = funct3_s;
        illegal_s     = (funct3_s == 3'b011) || (funct3_s[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec_s.alu_fn  = ALU_ADD;
        dec_s.op1     = rs1_val_s;
        dec_s.op2     = imm_s_s;
        dec_s.mem_wen = 1'b1;
        dec_s.mem_fn  = funct3_s;
        illegal_s     = funct3_s[2] || (funct3_s[1:0] == 2'b11);
      end
      OPC_BRANCH: begin
        dec_s.alu_fn = ALU_ADD;
        dec_s.op1    = in_pc;
        dec_s.op2    = imm_b_s;
        dec_s.br_en  = 1'b1;
        dec_s.br_fn  = funct3_s;
        illegal_s    = (funct3_s[2:1] == 2'b01);
      end
      OPC_JAL: begin
        dec_s.alu_fn  = ALU_ADD;
        dec_s.op1     = in_pc;
        dec_s.op2     = imm_j_s;
        dec_s.rd_addr = rd_s;
        dec_s.rf_wen  = (rd_s != 5'd0);
        dec_s.wb_sel  = WB_PC4;
        dec_s.jump    = 1'b1;
      end
      OPC_JALR: begin
        dec_s.alu_fn  = ALU_ADD;
        dec_s.op1     = rs1_val_s;
        dec_s.op2     = imm_i_s;
        dec_s.rd_addr = rd_s;
        dec_s.rf_wen  = (rd_s != 5'd0);
        dec_s.wb_sel  = WB_PC4;
        dec_s.jump    = 1'b1;
        illegal_s     = (funct3_s != 3'b000);
      end
      OPC_LUI: begin
        dec_s.alu_fn  = ALU_ADD;
        dec_s.op2     = imm_u_s;
        dec_s.rd_addr = rd_s;
        dec_s.rf_wen  = (rd_s != 5'd0);
      end
      OPC_AUIPC: begin
        dec_s.alu_fn  = ALU_ADD;
        dec_s.op1     = in_pc;
        dec_s.op2     = imm_u_s;
        dec_s.rd_addr = rd_s;
        dec_s.rf_wen  = (rd_s != 5'd0);
      end
      OPC_FENCE, OPC_SYSTEM: begin
        dec_s.alu_fn = ALU_X;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
    if (illegal_s) begin
      dec_s          = '0;
      dec_s.pc       = in_pc;
      dec_s.rs1_data = rs1_val_s;
      dec_s.rs2_data = rs2_val_s;
      dec_s.illegal  = 1'b1;
    end else begin
      dec_s.illegal  = 1'b0;
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign load_s   = in_valid && in_ready;

  // Pipeline register next state: flush > load > drain > hold
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load_s) begin
      valid_d  = 1'b1;
      bundle_d = dec_s;
    end else if (out_ready && !in_valid) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // ID/EX register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = bundle_q.pc;
  assign out_alu_fn   = bundle_q.alu_fn;
  assign out_op1      = bundle_q.op1;
  assign out_op2      = bundle_q.op2;
  assign out_rs1_data = bundle_q.rs1_data;
  assign out_rs2_data = bundle_q.rs2_data;
  assign out_rd_addr  = bundle_q.rd_addr;
  assign out_rf_wen   = bundle_q.rf_wen;
  assign out_wb_sel   = bundle_q.wb_sel;
  assign out_mem_wen  = bundle_q.mem_wen;
  assign out_mem_ren  = bundle_q.mem_ren;
  assign out_mem_fn   = bundle_q.mem_fn;
  assign out_br_en    = bundle_q.br_en;
  assign out_br_fn    = bundle_q.br_fn;
  assign out_jump     = bundle_q.jump;
  assign out_illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Randomised and directed bench for id_stage against a behavioural decode model.
module tb_id_stage;
  import id_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] in_pc, in_inst, rf_rs1_data, rf_rs2_data;
  logic        in_ready, out_valid;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] out_pc, out_op1, out_op2, out_rs1_data, out_rs2_data;
  logic [4:0]  out_alu_fn, out_rd_addr;
  logic        out_rf_wen, out_mem_wen, out_mem_ren, out_br_en, out_jump, out_illegal;
  logic [1:0]  out_wb_sel;
  logic [2:0]  out_mem_fn, out_br_fn;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  fn;
    logic [31:0] op1, op2, r1d, r2d;
    logic [4:0]  rd;
    logic        rf_wen;
    logic [1:0]  wb;
    logic        mem_wen, mem_ren;
    logic [2:0]  mem_fn;
    logic        br_en;
    logic [2:0]  br_fn;
    logic        jump, illegal;
  } exp_t;

  localparam logic [4:0] BASE_FN [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                         ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam logic [6:0] OPCS [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                       7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};

  exp_t m_b;
  logic m_valid;
  exp_t dut_b;

  assign dut_b = {out_pc, out_alu_fn, out_op1, out_op2, out_rs1_data, out_rs2_data,
                  out_rd_addr, out_rf_wen, out_wb_sel, out_mem_wen, out_mem_ren,
                  out_mem_fn, out_br_en, out_br_fn, out_jump, out_illegal};

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_alu_fn(out_alu_fn),
    .out_op1(out_op1), .out_op2(out_op2), .out_rs1_data(out_rs1_data),
    .out_rs2_data(out_rs2_data), .out_rd_addr(out_rd_addr), .out_rf_wen(out_rf_wen),
    .out_wb_sel(out_wb_sel), .out_mem_wen(out_mem_wen), .out_mem_ren(out_mem_ren),
    .out_mem_fn(out_mem_fn), .out_br_en(out_br_en), .out_br_fn(out_br_fn),
    .out_jump(out_jump), .out_illegal(out_illegal)
  );

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    return 32'($signed(v << (32 - bits)) >>> (32 - bits));
  endfunction

  // Behavioural RV32I decode from the instruction-set rules
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] inst,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [31:0] v1, v2, i_i, i_s, i_b, i_u, i_j, shamt;
    logic ill;
    op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25]; rd = inst[11:7];
    v1 = (inst[19:15] == 5'd0) ? 32'd0 : r1;
    v2 = (inst[24:20] == 5'd0) ? 32'd0 : r2;
    i_i = sext({20'd0, inst[31:20]}, 12);
    i_s = sext({20'd0, inst[31:25], inst[11:7]}, 12);
    i_b = sext({19'd0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13);
    i_u = {inst[31:12], 12'd0};
    i_j = sext({11'd0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21);
    shamt = 32'(inst[24:20]);
    ill = 1'b0;
    e = '0; e.pc = pc; e.fn = ALU_X; e.r1d = v1; e.r2d = v2;
    case (op)
      7'h33: begin
        e.op1 = v1; e.op2 = (f3 == 3'd1 || f3 == 3'd5) ? v2 % 32 : v2;
        e.rd = rd; e.rf_wen = (rd != 5'd0);
        if (f7 == 7'h00) e.fn = BASE_FN[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.fn = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.fn = ALU_SRA;
        else ill = 1'b1;
      end
      7'h13: begin
        e.op1 = v1; e.op2 = i_i; e.rd = rd; e.rf_wen = (rd != 5'd0); e.fn = BASE_FN[f3];
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.op2 = shamt;
          if (f3 == 3'd5 && f7 == 7'h20) e.fn = ALU_SRA;
          else if (f7 != 7'h00) ill = 1'b1;
        end
      end
      7'h03: begin
        e.fn = ALU_ADD; e.op1 = v1; e.op2 = i_i; e.rd = rd; e.rf_wen = (rd != 5'd0);
        e.wb = 2'd1; e.mem_ren = 1'b1; e.mem_fn = f3;
        ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      end
      7'h23: begin
        e.fn = ALU_ADD; e.op1 = v1; e.op2 = i_s; e.mem_wen = 1'b1; e.mem_fn = f3;
        ill = (f3 > 3'd2);
      end
      7'h63: begin
        e.fn = ALU_ADD; e.op1 = pc; e.op2 = i_b; e.br_en = 1'b1; e.br_fn = f3;
        ill = (f3 == 3'd2 || f3 == 3'd3);
      end
      7'h6F: begin
        e.fn = ALU_ADD; e.op1 = pc; e.op2 = i_j; e.rd = rd; e.rf_wen = (rd != 5'd0);
        e.wb = 2'd2; e.jump = 1'b1;
      end
      7'h67: begin
        e.fn = ALU_ADD; e.op1 = v1; e.op2 = i_i; e.rd = rd; e.rf_wen = (rd != 5'd0);
        e.wb = 2'd2; e.jump = 1'b1; ill = (f3 != 3'd0);
      end
      7'h37: begin e.fn = ALU_ADD; e.op2 = i_u; e.rd = rd; e.rf_wen = (rd != 5'd0); end
      7'h17: begin e.fn = ALU_ADD; e.op1 = pc; e.op2 = i_u; e.rd = rd; e.rf_wen = (rd != 5'd0); end
      7'h0F, 7'h73: e.fn = ALU_X;
      default: ill = 1'b1;
    endcase
    if (ill) begin
      e = '0; e.pc = pc; e.r1d = v1; e.r2d = v2; e.illegal = 1'b1;
    end
    return e;
  endfunction

  // Advance one clock, updating the reference register by the handshake priority rules
  task automatic tick();
    logic rdy;
    rdy = !m_valid || out_ready;
    if (!rst_n) begin
      m_valid = 1'b0; m_b = '0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (in_valid && rdy) begin
      m_valid = 1'b1; m_b = model(in_pc, in_inst, rf_rs1_data, rf_rs2_data);
    end else if (out_ready && !in_valid) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1; in_pc = pc; in_inst = inst; rf_rs1_data = r1; rf_rs2_data = r2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; flush = 1'b0;
    drive(32'h40, 32'h002081B3, 32'd1, 32'd2);
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (dut_b !== '0) begin bad++; $display("FAIL reset_bundle got=%h want=0", dut_b); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_decode();
    out_ready = 1'b1; flush = 1'b0;
    drive(32'h100, 32'h002081B3, 32'd5, 32'd7); #1;
    total++; if ({rf_rs1_addr, rf_rs2_addr} !== {5'd1, 5'd2}) begin
      bad++; $display("FAIL rf_addr got=%0d,%0d want=1,2", rf_rs1_addr, rf_rs2_addr); end
    tick();
    total++; if ({out_valid, out_alu_fn, out_op1, out_op2, out_rd_addr, out_rf_wen} !==
                 {1'b1, ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1}) begin
      bad++; $display("FAIL add got=%h/%0d want fn=%0d op1=5 op2=7 rd=3", out_op1, out_op2, ALU_ADD); end
    drive(32'h104, 32'h40335293, 32'h80000000, 32'd9); tick();
    total++; if ({out_alu_fn, out_op1, out_op2} !== {ALU_SRA, 32'h80000000, 32'd3}) begin
      bad++; $display("FAIL srai got fn=%0d op1=%h op2=%h want fn=%0d 80000000 3", out_alu_fn, out_op1, out_op2, ALU_SRA); end
    drive(32'h108, 32'h123450B7, 32'h55, 32'h66); tick();
    total++; if ({out_op1, out_op2, out_rd_addr} !== {32'd0, 32'h12345000, 5'd1}) begin
      bad++; $display("FAIL lui got op1=%h op2=%h rd=%0d want 0 12345000 1", out_op1, out_op2, out_rd_addr); end
    drive(32'h10C, 32'h000000B3, 32'hDEAD, 32'hBEEF); tick();
    total++; if ({out_op1, out_op2, out_rf_wen} !== {32'd0, 32'd0, 1'b1}) begin
      bad++; $display("FAIL x0_read got op1=%h op2=%h wen=%b want 0 0 1", out_op1, out_op2, out_rf_wen); end
    drive(32'h110, 32'h00208033, 32'd3, 32'd4); tick();
    total++; if (out_rf_wen !== 1'b0) begin bad++; $display("FAIL rd0_wen got=%b want=0", out_rf_wen); end
    drive(32'h114, 32'h010000EF, 32'd0, 32'd0); tick();
    total++; if ({out_jump, out_wb_sel, out_op1, out_op2} !== {1'b1, 2'd2, 32'h114, 32'd16}) begin
      bad++; $display("FAIL jal got jump=%b wb=%0d op1=%h op2=%h want 1 2 114 10", out_jump, out_wb_sel, out_op1, out_op2); end
    drive(32'h118, 32'hFE208CE3, 32'd1, 32'd2); tick();
    total++; if ({out_br_en, out_rf_wen, out_op2} !== {1'b1, 1'b0, 32'hFFFFFFF8}) begin
      bad++; $display("FAIL beq got br=%b wen=%b op2=%h want 1 0 fffffff8", out_br_en, out_rf_wen, out_op2); end
    drive(32'h11C, 32'h0020A423, 32'd100, 32'd77); tick();
    total++; if (dut_b !== m_b) begin bad++; $display("FAIL sw got=%h want=%h", dut_b, m_b); end
    drive(32'h120, 32'hFFC0A283, 32'd100, 32'd0); tick();
    total++; if ({out_mem_ren, out_wb_sel, out_op2, out_mem_fn} !== {1'b1, 2'd1, 32'hFFFFFFFC, 3'd2}) begin
      bad++; $display("FAIL lw got=%h want ren=1 wb=1 op2=-4 fn=2", dut_b); end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b1; flush = 1'b0;
    drive(32'h200, 32'h00100093, 32'd0, 32'd0); tick();
    out_ready = 1'b0;
    drive(32'h204, 32'h00200113, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", i, in_ready); end
      tick();
      total++; if ({out_valid, dut_b} !== {1'b1, m_b} || out_op2 !== 32'd1) begin
        bad++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", i, dut_b, m_b); end
    end
    out_ready = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    tick();
    total++; if ({out_valid, out_op2, out_rd_addr, out_pc} !== {1'b1, 32'd2, 5'd2, 32'h204}) begin
      bad++; $display("FAIL release_load got op2=%0d rd=%0d pc=%h want 2 2 204", out_op2, out_rd_addr, out_pc); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; flush = 1'b1;
    drive(32'h300, 32'h00300193, 32'd0, 32'd0); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", out_valid); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b want=0", out_valid); end
    drive(32'h310, 32'h00400213, 32'd0, 32'd0); tick();
    out_ready = 1'b0; drive(32'h314, 32'h00500293, 32'd0, 32'd0); tick();
    rst_n = 1'b0; tick();
    total++; if ({out_valid, dut_b} !== '0) begin bad++; $display("FAIL reset_stall got=%b/%h want=0", out_valid, dut_b); end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; tick();
  endtask

  task automatic test_illegal();
    logic [31:0] ill_insts [3];
    ill_insts = '{32'hFFFFFFFF, 32'h00002063, 32'h02109093};
    out_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h400 + 32'(i * 4), ill_insts[i], 32'd11, 32'd22); tick();
      total++; if ({out_valid, out_illegal, out_rf_wen, out_mem_wen, out_mem_ren, out_br_en, out_jump, out_alu_fn} !==
                   {1'b1, 1'b1, 5'd0, ALU_X}) begin
        bad++; $display("FAIL illegal inst=%h got=%h want illegal bundle", ill_insts[i], dut_b); end
    end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_random();
    logic [31:0] inst;
    for (int n = 0; n < 600; n++) begin
      inst = $urandom;
      if ($urandom_range(7) != 0) begin
        inst[6:0] = OPCS[$urandom_range(10)];
        if ($urandom_range(3) != 0) inst[31:25] = ($urandom_range(1) == 1) ? 7'h20 : 7'h00;
      end
      rst_n = ($urandom_range(63) != 0);
      flush = ($urandom_range(15) == 0);
      out_ready = ($urandom_range(2) != 0);
      drive({$urandom} & 32'hFFFFFFFC, inst, $urandom, $urandom);
      in_valid = ($urandom_range(3) != 0);
      #1;
      total++; if ({in_ready, rf_rs1_addr, rf_rs2_addr} !== {(!m_valid || out_ready), inst[19:15], inst[24:20]}) begin
        bad++; $display("FAIL rand_comb n=%0d got rdy=%b want=%b", n, in_ready, (!m_valid || out_ready)); end
      tick();
      total++; if (out_valid !== m_valid) begin
        bad++; $display("FAIL rand_valid n=%0d got=%b want=%b", n, out_valid, m_valid); end
      if (m_valid) begin
        total++; if (dut_b !== m_b) begin
          bad++; $display("FAIL rand_bundle n=%0d inst=%h got=%h want=%h", n, inst, dut_b, m_b); end
      end
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; tick();
  endtask

  initial begin
    m_valid = 1'b0; m_b = '0;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_pc = 32'd0; in_inst = 32'd0; rf_rs1_data = 32'd0; rf_rs2_data = 32'd0;
    test_reset();
    test_decode();
    test_stall();
    test_flush();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
